systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Issue-side controller for the systolic MAC row: accepts operand vectors over a valid/ready handshake and drives them into the array with per-lane diagonal skew. It also produces the one-cycle `done` pulse, one per completed vector, that the downstream done-counter consumes to raise `en_y`. One burst is exactly `BURST_LEN` vectors, so the counter sees exactly `BURST_LEN` pulses per burst, either contiguous or spaced.

## Interface
- `DATA_W`, 8, operand width per lane
- `LANES`, 4, number of MAC lanes (array width)
- `BURST_LEN`, 7, vectors per burst; must match the done-counter terminal count
- `MAC_LAT`, 3, cycles from last-lane operand to valid result in the array
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: begin a burst; sampled only in IDLE
- `in_valid` in 1: operand vector valid
- `in_ready` out 1: feeder can accept a vector
- `in_a` in LANES*DATA_W: A operands, lane k at bits [k*DATA_W +: DATA_W]
- `in_b` in LANES*DATA_W: B operands, same packing as `in_a`
- `out_a` out LANES*DATA_W: skewed A operands to the array
- `out_b` out LANES*DATA_W: skewed B operands to the array
- `out_valid` out LANES: per-lane operand valid
- `done` out 1: one-cycle pulse per completed vector
- `burst_end` out 1: one-cycle pulse coincident with the last `done` of a burst
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE:
  - `start`=1 → FEED.
  - Clear the issue count and the done count.
- FEED:
  - `in_ready`=1 while issue count < BURST_LEN.
  - Each accept (`in_valid`&&`in_ready` at a rising edge) increments the issue count and enters the skew line.
  - The accept that brings the issue count to BURST_LEN moves the FSM to DRAIN; `in_ready` drops on that edge.
- DRAIN:
  - `in_ready`=0.
  - When the done count reaches BURST_LEN, pulse `burst_end` and return to IDLE.
- Gaps: `in_valid` low for any number of cycles in FEED is legal. The feeder issues no vector and no `done` for those slots, so the `done` spacing mirrors the accept spacing.
- `start` outside IDLE is ignored. `start` and `in_valid` together in IDLE: the vector is not accepted, because `in_ready`=0 in IDLE.
- Skew: lane k's operands are delayed k cycles relative to lane 0. Where `out_valid[k]`=0, the corresponding `out_a` and `out_b` lane slices are driven to 0.
- Done tracking: a shift register of depth LANES+MAC_LAT carries one accept bit per cycle; its tail drives `done`. The done count saturates at BURST_LEN.
- Reset mid-burst: all pipeline bits are cleared. No `done` or `burst_end` is issued for vectors accepted before reset.

## Timing
- Reset values: `in_ready`=0, `out_a`=0, `out_b`=0, `out_valid`=0, `done`=0, `burst_end`=0, `busy`=0.
- `start` sampled at edge S: `busy`=1 and `in_ready`=1 from the cycle after S.
- Vector accepted at edge E:
  - `out_valid[k]`=1, with lane k data, during the cycle after edge E+k.
  - `done`=1 during the cycle after edge E+LANES+MAC_LAT−1, i.e. 7 cycles after E with the defaults.
- Back-to-back accepts give back-to-back `done` pulses; throughput is 1 vector per cycle.
- `burst_end` and the BURST_LEN-th `done` occur in the same cycle. `busy` drops the cycle after.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `systolic_pkg`:
  - `feeder_state_t` enum (IDLE, FEED, DRAIN)
  - default `LANES`, `DATA_W`, `BURST_LEN`, `MAC_LAT` constants shared with the done-counter
- Sub-module `mac_skew_line`: parameterised per-lane delay line (depth k, width 2*DATA_W+1 for a, b and valid), instantiated once per lane via generate.
- Top level holds the FSM, the issue and done counters, and the done shift register.

## Test plan
- Reset held for 2 cycles → every output 0. `start` during reset → no effect.
- `start`, then 7 back-to-back vectors → 7 contiguous `done` pulses, the first 7 cycles after the first accept. `burst_end` coincides with the 7th pulse; `busy`=0 on the next cycle.
- Vectors with `in_valid` on every other cycle → `done` pulses spaced by 2 cycles; still exactly 7 pulses; `burst_end` on the 7th.
- Skew check with `in_a`=0x04030201 → lane 0 sees 0x01 at accept+1, lane 1 sees 0x02 at +2, lane 2 sees 0x03 at +3, lane 3 sees 0x04 at +4. All other cycles: lane slice 0 and `out_valid[k]`=0.
- 8th `in_valid` held after 7 accepts → `in_ready`=0 and no 8th `done`. `start` pulsed in DRAIN → ignored.
- `reset` asserted after 3 accepts → no `done` within 10 cycles after release. A new burst then behaves as in the back-to-back scenario.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic MAC row feeder and its done-counter.
package systolic_pkg;

  localparam int DATA_W    = 8;
  localparam int LANES     = 4;
  localparam int BURST_LEN = 7;
  localparam int MAC_LAT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  // Counter width able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_skew_line.sv
// Per-lane operand delay line: one capture stage followed by DEPTH skew stages,
// so every lane output comes straight from a flop.
module mac_skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_r [DEPTH+1];

  // Capture the lane word and shift it down the skew stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DEPTH; i++) begin
        pipe_r[i] <= {W{1'b0}};
      end
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i <= DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign dout = pipe_r[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Issue-side controller for the systolic MAC row: accepts operand vectors, skews
// them per lane into the array and emits one done pulse per completed vector.
module systolic_feeder #(
  parameter int DATA_W    = systolic_pkg::DATA_W,
  parameter int LANES     = systolic_pkg::LANES,
  parameter int BURST_LEN = systolic_pkg::BURST_LEN,
  parameter int MAC_LAT   = systolic_pkg::MAC_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic [LANES*DATA_W-1:0] out_a,
  output logic [LANES*DATA_W-1:0] out_b,
  output logic [LANES-1:0]        out_valid,
  output logic                    done,
  output logic                    burst_end,
  output logic                    busy
);

  import systolic_pkg::*;

  localparam int CNT_W  = cnt_width(BURST_LEN);
  localparam int DONE_D = LANES + MAC_LAT;
  localparam int LW     = 2*DATA_W + 1;

  localparam logic [CNT_W-1:0] BURST_C      = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_LAST_C = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C       = CNT_W'(0);

  feeder_state_t     state_r, state_nxt_s;
  logic [CNT_W-1:0]  issue_cnt_r, issue_cnt_nxt_s;
  logic [CNT_W-1:0]  done_cnt_r, done_cnt_nxt_s;
  logic [DONE_D-1:0] done_sr_r;
  logic              in_ready_r, in_ready_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              burst_end_r, burst_end_nxt_s;
  logic              accept_s;
  logic              done_next_s;

  // in_ready_r is only ever high in FEED, so it fully qualifies the handshake.
  assign accept_s    = in_valid && in_ready_r;
  // Bit that becomes the done output on the coming edge.
  assign done_next_s = done_sr_r[DONE_D-2];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FEED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FEED: begin
        if (accept_s && (issue_cnt_r == BURST_LAST_C)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FEED;
        end
      end
      DRAIN: begin
        if (done_cnt_r == BURST_C) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of the counters and of the registered control outputs.
  always_comb begin
    issue_cnt_nxt_s = issue_cnt_r;
    done_cnt_nxt_s  = done_cnt_r;
    burst_end_nxt_s = 1'b0;
    if (state_r == IDLE) begin
      issue_cnt_nxt_s = ZERO_C;
      done_cnt_nxt_s  = ZERO_C;
    end else begin
      if (accept_s) begin
        issue_cnt_nxt_s = issue_cnt_r + ONE_C;
      end else begin
        issue_cnt_nxt_s = issue_cnt_r;
      end
      if (done_next_s && (done_cnt_r < BURST_C)) begin
        done_cnt_nxt_s = done_cnt_r + ONE_C;
      end else begin
        done_cnt_nxt_s = done_cnt_r;
      end
      // burst_end lines up with the done pulse that completes the burst.
      if (done_next_s && (done_cnt_r == BURST_LAST_C)) begin
        burst_end_nxt_s = 1'b1;
      end else begin
        burst_end_nxt_s = 1'b0;
      end
    end
    in_ready_nxt_s = (state_nxt_s == FEED);
    busy_nxt_s     = (state_nxt_s != IDLE);
  end

  // Counters, done tracking shift register and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt_r <= ZERO_C;
      done_cnt_r  <= ZERO_C;
      done_sr_r   <= {DONE_D{1'b0}};
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      burst_end_r <= 1'b0;
    end else begin
      issue_cnt_r <= issue_cnt_nxt_s;
      done_cnt_r  <= done_cnt_nxt_s;
      done_sr_r   <= {done_sr_r[DONE_D-2:0], accept_s};
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      burst_end_r <= burst_end_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign burst_end = burst_end_r;
  assign done      = done_sr_r[DONE_D-1];

  // Lane k sits k stages behind lane 0; non-accepted slots carry zeros.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LW-1:0] lane_d_s;
    logic [LW-1:0] lane_q_s;

    assign lane_d_s = accept_s
                    ? {1'b1, in_a[k*DATA_W +: DATA_W], in_b[k*DATA_W +: DATA_W]}
                    : {LW{1'b0}};

    mac_skew_line #(
      .DEPTH(k),
      .W    (LW)
    ) u_skew (
      .clk (clk),
      .rst (reset),
      .din (lane_d_s),
      .dout(lane_q_s)
    );

    assign out_valid[k]              = lane_q_s[LW-1];
    assign out_a[k*DATA_W +: DATA_W] = lane_q_s[2*DATA_W-1:DATA_W];
    assign out_b[k*DATA_W +: DATA_W] = lane_q_s[DATA_W-1:0];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a timestamp-based reference model.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int BL = 7;
  localparam int ML = 3;
  localparam int W  = L*DW;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_ready;
  logic [W-1:0]  out_a;
  logic [W-1:0]  out_b;
  logic [L-1:0]  out_valid;
  logic          done;
  logic          burst_end;
  logic          busy;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_W(DW), .LANES(L), .BURST_LEN(BL), .MAC_LAT(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .done(done), .burst_end(burst_end), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: history of accepts indexed by clock edge number.
  int           n = 0;
  int           last_rst = 0;
  bit           h_acc [HN];
  logic [W-1:0] h_a [HN];
  logic [W-1:0] h_b [HN];
  bit           m_busy = 1'b0;
  bit           m_ready = 1'b0;
  bit           be_pend = 1'b0;
  int           issued = 0;
  int           dones = 0;
  bit           exp_ready, exp_busy, exp_done, exp_be;
  logic [L-1:0] exp_ov;
  logic [W-1:0] exp_oa, exp_ob;

  function automatic bit was_acc(input int i);
    return (i >= 1 && i > last_rst && i < HN) ? h_acc[i] : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit acc;
    n++;
    if (reset) begin
      last_rst = n;
      h_acc[n] = 1'b0;
      m_busy = 1'b0; m_ready = 1'b0; be_pend = 1'b0; issued = 0; dones = 0;
      exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_be = 1'b0;
      exp_ov = '0; exp_oa = '0; exp_ob = '0;
    end else begin
      acc = m_ready && in_valid;
      h_acc[n] = acc; h_a[n] = in_a; h_b[n] = in_b;
      if (be_pend) begin
        m_busy = 1'b0; be_pend = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1; m_ready = 1'b1; issued = 0; dones = 0;
      end
      if (acc) begin
        issued++;
        if (issued == BL) m_ready = 1'b0;
      end
      // A vector accepted at edge E is done in the cycle after edge E+L+ML-1.
      exp_done = was_acc(n - (L + ML - 1));
      if (exp_done) dones++;
      exp_be = exp_done && (dones == BL);
      if (exp_be) be_pend = 1'b1;
      exp_ov = '0; exp_oa = '0; exp_ob = '0;
      for (int k = 0; k < L; k++) begin
        if (was_acc(n - k)) begin
          exp_ov[k] = 1'b1;
          exp_oa[k*DW +: DW] = h_a[n-k][k*DW +: DW];
          exp_ob[k*DW +: DW] = h_b[n-k][k*DW +: DW];
        end
      end
      exp_ready = m_ready;
      exp_busy  = m_busy;
    end
  end

  int dut_dones = 0;
  int dut_bes   = 0;

  // Compare every output mid-cycle; reset forces all-zero expectations.
  always @(negedge clk) begin
    check_eq("in_ready",  32'(in_ready),  reset ? 32'd0 : 32'(exp_ready));
    check_eq("busy",      32'(busy),      reset ? 32'd0 : 32'(exp_busy));
    check_eq("done",      32'(done),      reset ? 32'd0 : 32'(exp_done));
    check_eq("burst_end", 32'(burst_end), reset ? 32'd0 : 32'(exp_be));
    check_eq("out_valid", 32'(out_valid), reset ? 32'd0 : 32'(exp_ov));
    check_eq("out_a",     out_a,          reset ? 32'd0 : exp_oa);
    check_eq("out_b",     out_b,          reset ? 32'd0 : exp_ob);
    if (done) dut_dones++;
    if (burst_end) dut_bes++;
  end

  task automatic run_burst(input int mode, input bit skew);
    int sent, bc, dn0, be0;
    bit will;
    dn0 = dut_dones; be0 = dut_bes;
    start = 1'b1; in_valid = (mode == 0); in_a = $urandom; in_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; bc = 0;
    while (sent < BL && bc < 200) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (bc % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_a = (skew && sent == 0) ? 32'h04030201 : $urandom;
      in_b = $urandom;
      will = in_valid && m_ready;
      @(posedge clk); #1;
      if (will) sent++;
      bc++;
    end
    check_eq("accepts", sent, BL);
    // Hold an extra vector and poke start while draining: both must be ignored.
    in_valid = 1'b1;
    bc = 0;
    while (m_busy && bc < 100) begin
      start = (bc == 2);
      in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      bc++;
    end
    start = 1'b0; in_valid = 1'b0;
    check_eq("drain_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq("burst_dones", dut_dones - dn0, BL);
    check_eq("burst_ends",  dut_bes - be0, 1);
  endtask

  task automatic run_reset_mid();
    int dn0;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    dn0 = dut_dones;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_eq("post_rst_done", dut_dones - dn0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_burst(0, 1'b1);
    run_burst(1, 1'b0);
    run_burst(2, 1'b0);
    run_burst(2, 1'b1);
    run_reset_mid();
    run_burst(0, 1'b0);
    run_burst(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
